escalonador_chamadas: RTL and testbench

Elevator call scheduler for the 4-floor car. It latches floor calls from the confirm button and floor switches into a pending-call register, and serves them with a SCAN policy (keep direction while calls remain ahead). It tracks the car's current floor with a per-floor travel timer and sequences the door through the door-control handshake. It replaces the ad-hoc floor/door sequencing between the memory, floor-control and door blocks, and drives the movement LEDs and display floor value.

---
 rtl/elevador_pkg.sv | 6 +
 rtl/escalonador_chamadas_seletor.sv | 32 +++
 rtl/escalonador_chamadas.sv | 97 +++++++++
 tb/tb_escalonador_chamadas.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// elevador_pkg: floor type, floor count and scheduler states shared by the call scheduler
package elevador_pkg;
    localparam int NUM_ANDARES = 4;
    typedef logic [1:0] andar_t;
    typedef enum logic [2:0] {OCIOSO, MOVENDO, ABRINDO, ABERTA, FECHANDO} estado_t;
endpackage

// File: rtl/escalonador_chamadas_seletor.sv
// seletor_proximo_andar: SCAN target and direction choice from the pending-call bitmap
module seletor_proximo_andar
    import elevador_pkg::*;
(
    input  logic [NUM_ANDARES-1:0] chamadas,
    input  andar_t                 andar_atual,
    input  logic                   subindo,
    output andar_t                 andar_proximo,
    output logic                   subindo_novo,
    output logic                   a_frente,
    output logic                   atras
);
    logic [NUM_ANDARES-1:0] acima, abaixo;
    andar_t prox_acima, prox_abaixo;
    always_comb begin
        acima = '0;
        abaixo = '0;
        prox_acima = andar_atual;
        prox_abaixo = andar_atual;
        for (int i = 0; i < NUM_ANDARES; i++) begin
            acima[i] = chamadas[i] && (i > int'(andar_atual));
            abaixo[i] = chamadas[i] && (i < int'(andar_atual));
        end
        // last hit wins: lowest floor above, highest floor below
        for (int i = NUM_ANDARES - 1; i >= 0; i--) if (acima[i]) prox_acima = andar_t'(i);
        for (int i = 0; i < NUM_ANDARES; i++) if (abaixo[i]) prox_abaixo = andar_t'(i);
    end
    assign a_frente = subindo ? |acima : |abaixo;
    assign atras = subindo ? |abaixo : |acima;
    assign subindo_novo = subindo ^ (!a_frente && atras);
    assign andar_proximo = (subindo_novo ? |acima : |abaixo) ? (subindo_novo ? prox_acima : prox_abaixo) : andar_atual;
endmodule

// File: rtl/escalonador_chamadas.sv
// escalonador_chamadas: SCAN elevator call scheduler with floor travel timer and door handshake
// LOTACAO_EN: over-capacity alarm holds the door open while asserted
module escalonador_chamadas
    import elevador_pkg::*;
#(
    parameter int TEMPO_ANDAR = 4,
    parameter int TEMPO_PORTA = 6
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [1:0]             seletor_andar_chamada,
    input  logic                   pedido_valido,
    input  logic                   porta_aberta,
    input  logic                   porta_fechada,
    input  logic                   alerta_capacidade,
    output logic [1:0]             andar_atual,
    output logic [1:0]             andar_proximo,
    output logic                   subindo,
    output logic                   parado,
    output logic                   controle_porta,
    output logic [NUM_ANDARES-1:0] chamadas_pendentes,
    output logic                   ocupado
);
    estado_t estado, prox;
    logic [7:0] t_andar, t_porta;
    logic [NUM_ANDARES-1:0] pend;
    logic subindo_novo, a_frente, atras, porta_ativa, mesmo_andar, reabre, chega, segura, fim_porta, abriu;
    andar_t andar_seg;

    seletor_proximo_andar u_seletor (
        .chamadas      (chamadas_pendentes),
        .andar_atual   (andar_atual),
        .subindo       (subindo),
        .andar_proximo (andar_proximo),
        .subindo_novo  (subindo_novo),
        .a_frente      (a_frente),
        .atras         (atras)
    );

`ifdef LOTACAO_EN
    assign segura = estado == ABERTA && alerta_capacidade;
`else
    logic alerta_unused;
    assign alerta_unused = alerta_capacidade;
    assign segura = 1'b0;
`endif

    assign porta_ativa = estado == ABRINDO || estado == ABERTA;
    assign mesmo_andar = seletor_andar_chamada == andar_atual;
    assign reabre = pedido_valido && estado == ABERTA && mesmo_andar;
    assign pend = chamadas_pendentes | ((pedido_valido && !(porta_ativa && mesmo_andar)) ? 4'(1) << seletor_andar_chamada : '0);
    assign chega = estado == MOVENDO && tick && t_andar == 8'(TEMPO_ANDAR - 1);
    assign andar_seg = subindo ? andar_atual + 2'd1 : andar_atual - 2'd1;
    assign fim_porta = !reabre && !segura && (t_porta == 8'd0 || (tick && t_porta == 8'd1));
    assign abriu = estado == ABRINDO && porta_aberta;
    assign parado = estado != MOVENDO;
    assign controle_porta = porta_ativa;
    assign ocupado = estado != OCIOSO;

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:   prox = chamadas_pendentes[andar_atual] ? ABRINDO : (a_frente || atras) ? MOVENDO : OCIOSO;
            MOVENDO:  prox = (chega && pend[andar_seg]) ? ABRINDO : MOVENDO;
            ABRINDO:  prox = porta_aberta ? ABERTA : ABRINDO;
            ABERTA:   prox = fim_porta ? FECHANDO : ABERTA;
            FECHANDO: prox = porta_fechada ? OCIOSO : FECHANDO;
            default:  prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            estado <= OCIOSO;
            andar_atual <= '0;
            subindo <= 1'b1;
            chamadas_pendentes <= '0;
            t_andar <= '0;
            t_porta <= '0;
        end else begin
            estado <= prox;
            chamadas_pendentes <= abriu ? pend & ~(4'(1) << andar_atual) : pend;
            if (estado == OCIOSO && !chamadas_pendentes[andar_atual]) begin
                subindo <= subindo_novo;
                t_andar <= '0;
            end else if (chega) begin
                andar_atual <= andar_seg;
                t_andar <= '0;
            end else if (estado == MOVENDO && tick) begin
                t_andar <= t_andar + 8'd1;
            end
            t_porta <= (abriu || reabre || segura) ? 8'(TEMPO_PORTA) :
                       (estado == ABERTA && tick && t_porta != 8'd0) ? t_porta - 8'd1 : t_porta;
        end
    end
endmodule

// File: tb/tb_escalonador_chamadas.sv
// tb_escalonador_chamadas: directed checks of the call scheduler against a 2-cycle door model
module tb_escalonador_chamadas;
    logic clock_in = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b1;
    logic pedido_valido = 1'b0;
    logic alerta_capacidade = 1'b0;
    logic [1:0] seletor_andar_chamada = 2'd0;
    logic porta_aberta, porta_fechada;
    logic [1:0] andar_atual, andar_proximo;
    logic subindo, parado, controle_porta, ocupado;
    logic [3:0] chamadas_pendentes;
    int vetores = 0;
    int erros = 0;
    int aberta_cnt = 0;
    int fechada_cnt = 0;
    logic rst_q = 1'b1;
    logic [1:0] andar_ant = 2'd0;

    escalonador_chamadas #(.TEMPO_ANDAR(4), .TEMPO_PORTA(6)) dut (
        .clock_in              (clock_in),
        .reset                 (reset),
        .tick                  (tick),
        .seletor_andar_chamada (seletor_andar_chamada),
        .pedido_valido         (pedido_valido),
        .porta_aberta          (porta_aberta),
        .porta_fechada         (porta_fechada),
        .alerta_capacidade     (alerta_capacidade),
        .andar_atual           (andar_atual),
        .andar_proximo         (andar_proximo),
        .subindo               (subindo),
        .parado                (parado),
        .controle_porta        (controle_porta),
        .chamadas_pendentes    (chamadas_pendentes),
        .ocupado               (ocupado)
    );

    always #5 clock_in = ~clock_in;

    // door answers two cycles after the command changes
    always @(posedge clock_in) begin
        aberta_cnt <= controle_porta ? aberta_cnt + 1 : 0;
        fechada_cnt <= controle_porta ? 0 : (fechada_cnt < 3 ? fechada_cnt + 1 : 3);
        rst_q <= reset;
    end
    assign porta_aberta = controle_porta && aberta_cnt >= 2;
    assign porta_fechada = !controle_porta && fechada_cnt >= 2;

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vetores++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
        end
    endtask

    task automatic passo(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic pedir(input logic [1:0] f);
        seletor_andar_chamada = f;
        pedido_valido = 1'b1;
        @(negedge clock_in);
        pedido_valido = 1'b0;
    endtask

    task automatic esperar_livre(input string tag);
        int n = 0;
        while (ocupado && n < 200) begin
            @(negedge clock_in);
            n++;
        end
        verificar(tag, ocupado, 0);
    endtask

    task automatic medir_porta(output int n);
        n = 0;
        while (controle_porta && n < 100) begin
            n++;
            @(negedge clock_in);
        end
    endtask

    // the car must only ever move one floor at a time
    always @(negedge clock_in) begin
        int d;
        d = int'(andar_atual) - int'(andar_ant);
        if (!rst_q && d != 0) verificar("passo_andar", d == 1 || d == -1, 1);
        andar_ant = andar_atual;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        passo(2);
        verificar("rst_andar", andar_atual, 0);
        verificar("rst_prox", andar_proximo, 0);
        verificar("rst_pend", chamadas_pendentes, 0);
        verificar("rst_subindo", subindo, 1);
        verificar("rst_parado", parado, 1);
        verificar("rst_porta", controle_porta, 0);
        verificar("rst_ocupado", ocupado, 0);
        reset = 1'b0;

        pedir(2'd2);
        verificar("s1_pend", chamadas_pendentes, 4'b0100);
        verificar("s1_ocioso", ocupado, 0);
        passo(1);
        verificar("s1_parado", parado, 0);
        verificar("s1_subindo", subindo, 1);
        verificar("s1_prox", andar_proximo, 2);
        passo(3);
        verificar("s1_andar_3t", andar_atual, 0);
        passo(1);
        verificar("s1_andar_4t", andar_atual, 1);
        passo(4);
        verificar("s1_andar_8t", andar_atual, 2);
        verificar("s1_abrindo", controle_porta, 1);
        verificar("s1_pend_abrindo", chamadas_pendentes, 4'b0100);
        passo(3);
        verificar("s1_pend_limpa", chamadas_pendentes, 0);
        medir_porta(n);
        verificar("s1_dwell", n, 6);
        esperar_livre("s1_livre");
        verificar("s1_parado_fim", parado, 1);

        reset = 1'b1;
        passo(1);
        reset = 1'b0;
        pedir(2'd3);
        passo(2);
        pedir(2'd0);
        passo(2);
        verificar("s2_andar1", andar_atual, 1);
        verificar("s2_pend", chamadas_pendentes, 4'b1001);
        verificar("s2_subindo", subindo, 1);
        verificar("s2_prox3", andar_proximo, 3);
        passo(8);
        verificar("s2_andar3", andar_atual, 3);
        verificar("s2_abre3", controle_porta, 1);
        esperar_livre("s2_livre3");
        verificar("s2_subindo_antes", subindo, 1);
        verificar("s2_pend0", chamadas_pendentes, 4'b0001);
        passo(1);
        verificar("s2_reverte", subindo, 0);
        verificar("s2_prox0", andar_proximo, 0);
        passo(12);
        verificar("s2_andar0", andar_atual, 0);
        verificar("s2_abre0", controle_porta, 1);
        esperar_livre("s2_livre0");

        pedir(2'd0);
        passo(1);
        verificar("s3_abrindo", controle_porta, 1);
        verificar("s3_pend", chamadas_pendentes, 4'b0001);
        passo(3);
        verificar("s3_aberta", chamadas_pendentes, 0);
        passo(2);
        pedir(2'd0);
        verificar("s3_sem_bit", chamadas_pendentes, 0);
        verificar("s3_porta", controle_porta, 1);
        medir_porta(n);
        verificar("s3_reinicio", n, 6);
        esperar_livre("s3_livre");

        pedir(2'd0);
        passo(1);
        n = 0;
        while (controle_porta && n < 100) begin
            n++;
            if (n == 4) alerta_capacidade = 1'b1;
            if (n == 24) alerta_capacidade = 1'b0;
            passo(1);
        end
        alerta_capacidade = 1'b0;
`ifdef LOTACAO_EN
        verificar("s4_lotacao", n, 29);
`else
        verificar("s4_lotacao", n, 9);
`endif
        esperar_livre("s4_livre");

        pedir(2'd3);
        passo(9);
        verificar("s5_andar2", andar_atual, 2);
        verificar("s5_movendo", parado, 0);
        passo(1);
        reset = 1'b1;
        passo(1);
        verificar("s5_andar", andar_atual, 0);
        verificar("s5_pend", chamadas_pendentes, 0);
        verificar("s5_parado", parado, 1);
        verificar("s5_porta", controle_porta, 0);
        verificar("s5_ocupado", ocupado, 0);
        verificar("s5_subindo", subindo, 1);
        reset = 1'b0;
        passo(2);

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end
endmodule
